// File: rtl/cues_sw_pkg.sv
// Shared definitions for the CPB-side token switch.
//   - Default field widths used by tok_route_sw parameters.
//   - tok_t: the token payload at default widths.
//   - dest_e: destination selector, plus the routing decode helper.
package cues_sw_pkg;

    localparam int DFLT_NODE_W = 16;
    localparam int DFLT_GEN_W  = 12;
    localparam int DFLT_OPR_W  = 32;
    localparam int DFLT_PE_W   = 3;

    typedef struct packed {
        logic                   lr;
        logic [DFLT_NODE_W-1:0] node;
        logic [DFLT_GEN_W-1:0]  gen;
        logic [DFLT_OPR_W-1:0]  opr;
        logic                   uni_opr;
        logic [DFLT_PE_W-1:0]   pe_num;
        logic                   mem_w;
    } tok_t;

    typedef enum logic {
        DEST_MER = 1'b0,
        DEST_ICN = 1'b1
    } dest_e;

    // Local PE tokens go to Mer unless they carry a memory write, which
    // always has to travel over the interconnect.
    function automatic dest_e route_dest(input logic is_local, input logic mem_w);
        return (is_local && !mem_w) ? DEST_MER : DEST_ICN;
    endfunction

endpackage

// File: rtl/tok_fifo.sv
// DEPTH-entry synchronous FIFO with valid/ready on both sides.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data    : write side
//   out_valid/out_ready/out_data : read side, out_data is storage[rd_ptr]
//   count                        : occupancy 0..DEPTH
// Handshake: a transfer happens on a clock edge where valid && ready are
// both high; valid never depends on ready, and the producer holds data
// stable while valid && !ready.
// in_ready only looks at count, so a full FIFO will not accept a push in
// the same cycle as a pop; the freed slot is usable next cycle.
module tok_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage is cleared on reset so heads read zero rather than stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tok_route_sw.sv
// Token switch between the CPB and its two consumers: Mer (local PE) and
// ICN (remote PE or any memory write). Each destination has its own FIFO so
// a stalled ICN does not block Mer traffic.
// Ports:
//   clk, rst (async, active-low)
//   in_*   : CPB token with in_valid/in_ready
//   icn_*  : ICN head token with icn_valid/icn_ready; icn_mem_w is 2 bits
//   mer_*  : Mer head token with mer_valid/mer_ready
//   icn_count, mer_count : FIFO occupancies
// Optional (macro TOK_ROUTE_SW_STAT_EN): stat_clr input and 32-bit
// stat_icn_tok / stat_mer_tok accepted-token counters.
module tok_route_sw
    import cues_sw_pkg::*;
#(
    parameter int NODE_W   = DFLT_NODE_W,
    parameter int GEN_W    = DFLT_GEN_W,
    parameter int OPR_W    = DFLT_OPR_W,
    parameter int PE_W     = DFLT_PE_W,
    parameter int LOCAL_PE = 0,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_lr,
    input  logic [NODE_W-1:0]      in_node,
    input  logic [GEN_W-1:0]       in_gen,
    input  logic [OPR_W-1:0]       in_opr,
    input  logic                   in_uni_opr,
    input  logic [PE_W-1:0]        in_pe_num,
    input  logic                   in_mem_w,
    output logic                   icn_valid,
    input  logic                   icn_ready,
    output logic [PE_W-1:0]        icn_pe_num,
    output logic [1:0]             icn_mem_w,
    output logic                   icn_lr,
    output logic [NODE_W-1:0]      icn_node,
    output logic [GEN_W-1:0]       icn_gen,
    output logic [OPR_W-1:0]       icn_opr,
    output logic                   icn_uni_opr,
    output logic                   mer_valid,
    input  logic                   mer_ready,
    output logic                   mer_lr,
    output logic [NODE_W-1:0]      mer_node,
    output logic [GEN_W-1:0]       mer_gen,
    output logic [OPR_W-1:0]       mer_opr,
    output logic                   mer_uni_opr,
    output logic [$clog2(DEPTH):0] icn_count,
    output logic [$clog2(DEPTH):0] mer_count
`ifdef TOK_ROUTE_SW_STAT_EN
    ,
    input  logic                   stat_clr,
    output logic [31:0]            stat_icn_tok,
    output logic [31:0]            stat_mer_tok
`endif
);

    // Mer never needs pe_num or mem_w, so its FIFO is narrower.
    localparam int MER_W = 1 + NODE_W + GEN_W + OPR_W + 1;
    localparam int ICN_W = MER_W + PE_W + 1;

    dest_e            dest;
    logic             icn_in_ready;
    logic             mer_in_ready;
    logic             icn_push;
    logic             mer_push;
    logic [ICN_W-1:0] icn_data;
    logic [MER_W-1:0] mer_data;
    logic             icn_mem_bit;

    assign dest     = route_dest(in_pe_num == PE_W'(LOCAL_PE), in_mem_w);
    assign in_ready = (dest == DEST_MER) ? mer_in_ready : icn_in_ready;
    assign icn_push = in_valid && in_ready && (dest == DEST_ICN);
    assign mer_push = in_valid && in_ready && (dest == DEST_MER);

    tok_fifo #(.DEPTH(DEPTH), .W(ICN_W)) u_icn_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && (dest == DEST_ICN)),
        .in_ready  (icn_in_ready),
        .in_data   ({in_lr, in_node, in_gen, in_opr, in_uni_opr, in_pe_num, in_mem_w}),
        .out_valid (icn_valid),
        .out_ready (icn_ready),
        .out_data  (icn_data),
        .count     (icn_count)
    );

    tok_fifo #(.DEPTH(DEPTH), .W(MER_W)) u_mer_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && (dest == DEST_MER)),
        .in_ready  (mer_in_ready),
        .in_data   ({in_lr, in_node, in_gen, in_opr, in_uni_opr}),
        .out_valid (mer_valid),
        .out_ready (mer_ready),
        .out_data  (mer_data),
        .count     (mer_count)
    );

    assign {icn_lr, icn_node, icn_gen, icn_opr, icn_uni_opr, icn_pe_num, icn_mem_bit} = icn_data;
    assign {mer_lr, mer_node, mer_gen, mer_opr, mer_uni_opr} = mer_data;

    // ICN expects memory writes flagged on both bits.
    assign icn_mem_w = {2{icn_mem_bit}};

`ifdef TOK_ROUTE_SW_STAT_EN
    // Clear takes priority over a same-cycle increment; counters wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_icn_tok <= '0;
            stat_mer_tok <= '0;
        end else if (stat_clr) begin
            stat_icn_tok <= '0;
            stat_mer_tok <= '0;
        end else begin
            if (icn_push) stat_icn_tok <= stat_icn_tok + 32'd1;
            if (mer_push) stat_mer_tok <= stat_mer_tok + 32'd1;
        end
    end
`else
    // Push strobes only feed the statistics counters.
    logic unused_push;
    assign unused_push = icn_push ^ mer_push;
`endif

endmodule

// File: tb/tb_tok_route_sw.sv
module tb_tok_route_sw;

    localparam int NODE_W   = 16;
    localparam int GEN_W    = 12;
    localparam int OPR_W    = 32;
    localparam int PE_W     = 3;
    localparam int LOCAL_PE = 2;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_lr;
    logic [NODE_W-1:0] in_node;
    logic [GEN_W-1:0]  in_gen;
    logic [OPR_W-1:0]  in_opr;
    logic              in_uni_opr;
    logic [PE_W-1:0]   in_pe_num;
    logic              in_mem_w;
    logic              icn_valid;
    logic              icn_ready;
    logic [PE_W-1:0]   icn_pe_num;
    logic [1:0]        icn_mem_w;
    logic              icn_lr;
    logic [NODE_W-1:0] icn_node;
    logic [GEN_W-1:0]  icn_gen;
    logic [OPR_W-1:0]  icn_opr;
    logic              icn_uni_opr;
    logic              mer_valid;
    logic              mer_ready;
    logic              mer_lr;
    logic [NODE_W-1:0] mer_node;
    logic [GEN_W-1:0]  mer_gen;
    logic [OPR_W-1:0]  mer_opr;
    logic              mer_uni_opr;
    logic [CNT_W-1:0]  icn_count;
    logic [CNT_W-1:0]  mer_count;
`ifdef TOK_ROUTE_SW_STAT_EN
    logic              stat_clr;
    logic [31:0]       stat_icn_tok;
    logic [31:0]       stat_mer_tok;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic sb_on  = 1'b0;
    logic [OPR_W-1:0] exp_q[$];

    tok_route_sw #(
        .NODE_W(NODE_W), .GEN_W(GEN_W), .OPR_W(OPR_W), .PE_W(PE_W),
        .LOCAL_PE(LOCAL_PE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_lr(in_lr),
        .in_node(in_node), .in_gen(in_gen), .in_opr(in_opr),
        .in_uni_opr(in_uni_opr), .in_pe_num(in_pe_num), .in_mem_w(in_mem_w),
        .icn_valid(icn_valid), .icn_ready(icn_ready), .icn_pe_num(icn_pe_num),
        .icn_mem_w(icn_mem_w), .icn_lr(icn_lr), .icn_node(icn_node),
        .icn_gen(icn_gen), .icn_opr(icn_opr), .icn_uni_opr(icn_uni_opr),
        .mer_valid(mer_valid), .mer_ready(mer_ready), .mer_lr(mer_lr),
        .mer_node(mer_node), .mer_gen(mer_gen), .mer_opr(mer_opr),
        .mer_uni_opr(mer_uni_opr),
        .icn_count(icn_count), .mer_count(mer_count)
`ifdef TOK_ROUTE_SW_STAT_EN
        ,
        .stat_clr(stat_clr), .stat_icn_tok(stat_icn_tok), .stat_mer_tok(stat_mer_tok)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tok(input logic [PE_W-1:0] pe, input logic mw, input logic [OPR_W-1:0] opr,
                           input logic lr, input logic [NODE_W-1:0] node,
                           input logic [GEN_W-1:0] gen, input logic uni);
        in_valid   = 1'b1;
        in_pe_num  = pe;
        in_mem_w   = mw;
        in_opr     = opr;
        in_lr      = lr;
        in_node    = node;
        in_gen     = gen;
        in_uni_opr = uni;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Present a token until the handshake completes, with a cycle bound.
    task automatic send_tok(input logic [PE_W-1:0] pe, input logic mw, input logic [OPR_W-1:0] opr);
        logic acc;
        acc = 1'b0;
        set_tok(pe, mw, opr, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 40 && !acc; c++) begin
            settle();
            acc = in_ready;
            step();
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: opr %0h not accepted within 40 cycles", opr);
        end
    endtask

    // ---------------- scoreboard: ICN output order ----------------
    always @(negedge clk) begin
        if (sb_on && icn_valid && icn_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check("sb_extra_pop", 64'(icn_opr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_icn_order", 64'(icn_opr), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [PE_W-1:0]   pe;
        logic              mw;
        logic [OPR_W-1:0]  opr;
        logic              lr;
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic              uni;
        logic              exp_mer;
        logic [1:0]        exp_mw2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3'd2, 1'b0, 32'hDEADBEEF, 1'b1, 16'h1234, 12'hABC, 1'b0, 1'b1, 2'b00};
        vecs[1] = '{3'd5, 1'b0, 32'h12345678, 1'b0, 16'h00FF, 12'h001, 1'b1, 1'b0, 2'b00};
        vecs[2] = '{3'd2, 1'b1, 32'hCAFEF00D, 1'b1, 16'hFFFF, 12'hFFF, 1'b1, 1'b0, 2'b11};
        vecs[3] = '{3'd0, 1'b0, 32'h00000001, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 2'b00};
        vecs[4] = '{3'd7, 1'b1, 32'hFFFFFFFF, 1'b1, 16'h8000, 12'h800, 1'b0, 1'b0, 2'b11};
        vecs[5] = '{3'd2, 1'b0, 32'h80000000, 1'b0, 16'h0001, 12'h7FF, 1'b1, 1'b1, 2'b00};

        rst = 1'b0;
        in_valid = 1'b0; in_lr = 1'b0; in_node = '0; in_gen = '0; in_opr = '0;
        in_uni_opr = 1'b0; in_pe_num = '0; in_mem_w = 1'b0;
        icn_ready = 1'b0; mer_ready = 1'b0;
`ifdef TOK_ROUTE_SW_STAT_EN
        stat_clr = 1'b0;
`endif

        // Reset state
        #3;
        check("rst_icn_count", 64'(icn_count), 64'd0);
        check("rst_mer_count", 64'(mer_count), 64'd0);
        check("rst_valids", 64'({icn_valid, mer_valid}), 64'd0);
        check("rst_icn_mem_w", 64'(icn_mem_w), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b1;
        step();

        // Routing table, both consumers ready
        icn_ready = 1'b1;
        mer_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_tok(vecs[i].pe, vecs[i].mw, vecs[i].opr, vecs[i].lr, vecs[i].node, vecs[i].gen, vecs[i].uni);
            settle();
            check("vec_in_ready", 64'(in_ready), 64'd1);
            check("vec_no_comb_path", 64'({mer_valid, icn_valid}), 64'd0);
            step();
            idle();
            settle();
            check("vec_mer_valid", 64'(mer_valid), 64'(vecs[i].exp_mer));
            check("vec_icn_valid", 64'(icn_valid), 64'(!vecs[i].exp_mer));
            if (vecs[i].exp_mer) begin
                check("vec_mer_opr", 64'(mer_opr), 64'(vecs[i].opr));
                check("vec_mer_node", 64'(mer_node), 64'(vecs[i].node));
                check("vec_mer_gen", 64'(mer_gen), 64'(vecs[i].gen));
                check("vec_mer_flags", 64'({mer_lr, mer_uni_opr}), 64'({vecs[i].lr, vecs[i].uni}));
            end else begin
                check("vec_icn_opr", 64'(icn_opr), 64'(vecs[i].opr));
                check("vec_icn_node", 64'(icn_node), 64'(vecs[i].node));
                check("vec_icn_gen", 64'(icn_gen), 64'(vecs[i].gen));
                check("vec_icn_flags", 64'({icn_lr, icn_uni_opr}), 64'({vecs[i].lr, vecs[i].uni}));
                check("vec_icn_pe_num", 64'(icn_pe_num), 64'(vecs[i].pe));
                check("vec_icn_mem_w", 64'(icn_mem_w), 64'(vecs[i].exp_mw2));
            end
            step();
            check("vec_drained", 64'({mer_count, icn_count}), 64'd0);
        end

        // Two ICN tokens in order, mem_w expansion
        icn_ready = 1'b0;
        send_tok(3'd5, 1'b0, 32'h0000_0011);
        send_tok(3'd2, 1'b1, 32'h0000_0022);
        idle();
        settle();
        check("ord_icn_count", 64'(icn_count), 64'd2);
        check("ord_mer_valid", 64'(mer_valid), 64'd0);
        check("ord_head0_opr", 64'(icn_opr), 64'h11);
        check("ord_head0_mem_w", 64'(icn_mem_w), 64'b00);
        icn_ready = 1'b1;
        step();
        check("ord_head1_opr", 64'(icn_opr), 64'h22);
        check("ord_head1_mem_w", 64'(icn_mem_w), 64'b11);
        check("ord_mer_valid2", 64'(mer_valid), 64'd0);
        step();
        check("ord_drained", 64'(icn_count), 64'd0);

        // Backpressure, independence, and 16-token stream with wrap
        icn_ready = 1'b0;
        mer_ready = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(32'hA000_0000 + k);
        n_pops = 0;
        sb_on = 1'b1;
        for (int k = 0; k < 4; k++) send_tok(3'd5, 1'b0, 32'hA000_0000 + k);
        idle();
        settle();
        check("bp_icn_full", 64'(icn_count), 64'd4);
        check("bp_head", 64'(icn_opr), 64'hA000_0000);
        set_tok(3'd5, 1'b0, 32'hA000_0004, 1'b0, '0, '0, 1'b0);
        settle();
        check("bp_icn_in_ready", 64'(in_ready), 64'd0);
        set_tok(3'd2, 1'b0, 32'h5555_0000, 1'b0, '0, '0, 1'b0);
        settle();
        check("bp_mer_in_ready", 64'(in_ready), 64'd1);
        step();
        idle();
        settle();
        check("bp_mer_count", 64'(mer_count), 64'd1);
        check("bp_icn_count_hold", 64'(icn_count), 64'd4);
        check("bp_head_stable", 64'(icn_opr), 64'hA000_0000);
        icn_ready = 1'b1;
        set_tok(3'd5, 1'b0, 32'hA000_0004, 1'b0, '0, '0, 1'b0);
        settle();
        check("bp_full_no_push", 64'(in_ready), 64'd0);
        step();
        settle();
        check("bp_after_pop_count", 64'(icn_count), 64'd3);
        check("bp_resume_ready", 64'(in_ready), 64'd1);
        for (int k = 4; k < 16; k++) send_tok(3'd5, 1'b0, 32'hA000_0000 + k);
        idle();
        begin
            int c;
            c = 0;
            while (icn_count != 0 && c < 20) begin
                step();
                c++;
            end
            check("stream_drain_timeout", 64'(icn_count), 64'd0);
        end
        step();
        sb_on = 1'b0;
        check("stream_pops", 64'(n_pops), 64'd16);
        check("stream_q_empty", 64'(exp_q.size()), 64'd0);
        mer_ready = 1'b1;
        settle();
        check("bp_mer_head", 64'(mer_opr), 64'h5555_0000);
        step();
        check("bp_mer_drained", 64'(mer_count), 64'd0);

        // Asynchronous reset mid-stream
        icn_ready = 1'b0;
        mer_ready = 1'b0;
        send_tok(3'd5, 1'b1, 32'hB000_0000);
        send_tok(3'd3, 1'b0, 32'hB000_0001);
        send_tok(3'd6, 1'b0, 32'hB000_0002);
        send_tok(3'd2, 1'b0, 32'hC000_0000);
        send_tok(3'd2, 1'b0, 32'hC000_0001);
        set_tok(3'd2, 1'b0, 32'hC000_0002, 1'b1, 16'hAAAA, 12'h555, 1'b1);
        settle();
        check("mid_icn_count", 64'(icn_count), 64'd3);
        check("mid_mer_count", 64'(mer_count), 64'd2);
        check("mid_icn_mem_w", 64'(icn_mem_w), 64'b11);
        #2;
        rst = 1'b0;
        #1;
        check("arst_counts", 64'({icn_count, mer_count}), 64'd0);
        check("arst_valids", 64'({icn_valid, mer_valid}), 64'd0);
        check("arst_icn_opr", 64'(icn_opr), 64'd0);
        check("arst_icn_mem_w", 64'(icn_mem_w), 64'd0);
        check("arst_icn_pe", 64'(icn_pe_num), 64'd0);
        check("arst_mer_opr", 64'(mer_opr), 64'd0);
        step();
        check("arst_held_counts", 64'({icn_count, mer_count}), 64'd0);
        rst = 1'b1;
        set_tok(3'd2, 1'b0, 32'hD000_0000, 1'b0, 16'h0042, 12'h00A, 1'b0);
        step();
        idle();
        settle();
        check("rel_mer_valid", 64'(mer_valid), 64'd1);
        check("rel_mer_opr", 64'(mer_opr), 64'hD000_0000);
        check("rel_mer_node", 64'(mer_node), 64'h0042);
        check("rel_mer_count", 64'(mer_count), 64'd1);
        check("rel_icn_empty", 64'({icn_valid, icn_count}), 64'd0);
        mer_ready = 1'b1;
        icn_ready = 1'b1;
        step();
        check("rel_drained", 64'(mer_count), 64'd0);

`ifdef TOK_ROUTE_SW_STAT_EN
        // Counters were reset; D000_0000 already counted as one Mer token.
        send_tok(3'd2, 1'b0, 32'hE000_0000);
        send_tok(3'd2, 1'b0, 32'hE000_0001);
        send_tok(3'd4, 1'b0, 32'hE000_0002);
        send_tok(3'd2, 1'b1, 32'hE000_0003);
        idle();
        settle();
        check("stat_mer", 64'(stat_mer_tok), 64'd3);
        check("stat_icn", 64'(stat_icn_tok), 64'd2);
        stat_clr = 1'b1;
        set_tok(3'd1, 1'b0, 32'hE000_0004, 1'b0, '0, '0, 1'b0);
        step();
        stat_clr = 1'b0;
        idle();
        settle();
        check("stat_clr_icn", 64'(stat_icn_tok), 64'd0);
        check("stat_clr_mer", 64'(stat_mer_tok), 64'd0);
        send_tok(3'd1, 1'b0, 32'hE000_0005);
        idle();
        settle();
        check("stat_after_clr", 64'(stat_icn_tok), 64'd1);
        step();
`endif

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
